key_irq_ctrl: RTL and testbench
===============================

// Module: key_irq_ctrl
// PURPOSE
//  Upstream interrupt source for the pipelined core. It synchronises and debounces the raw active-low KEY inputs.
//  It detects presses, holds one pending bit per line, and picks the highest-priority enabled line.
//  It then drives a single interrupt request with a one-hot cause vector into the Cause/EPC/Status logic.
//  Nested requests are blocked: a new request is only raised after i_eret.
// PARAMETERS
//  N_KEYS           2      number of key lines; bit 0 has the highest priority
//  DEBOUNCE_CYCLES  50000  cycles a synchronised level must hold before it is accepted (1 ms @ 50 MHz); must be >= 2
//  CNT_W            16     debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  Clk         in   1       system clock, rising edge
//  Reset       in   1       asynchronous, active-low reset
//  i_key       in   N_KEYS  raw key levels, asynchronous, 0 = pressed
//  i_ie        in   N_KEYS  per-line enable (Status[8+i])
//  i_gie       in   1       global interrupt enable (Status[0])
//  i_ack       in   1       1-cycle pulse: the core has taken the interrupt (EPC/Cause written)
//  i_eret      in   1       1-cycle pulse: the handler has returned
//  i_clr       in   1       software clear strobe
//  i_clr_mask  in   N_KEYS  pending bits to clear when i_clr=1
//  o_irq       out  1       registered interrupt request to the core
//  o_cause_ip  out  N_KEYS  one-hot line being requested/serviced (Cause IP field)
//  o_pending   out  N_KEYS  pending flags, readable by software
//  o_key       out  N_KEYS  debounced key levels, 0 = pressed
// BEHAVIOUR
//  Reset values
//   - sync flops and o_key: all 1s. Counters: 0.
//   - o_pending, o_cause_ip, o_irq: 0. FSM: IDLE.
//  Synchroniser
//   - 2-flop synchroniser per line gives s[i].
//  Debounce (per line)
//   - If s[i] == o_key[i]: cnt[i] <= 0.
//   - Otherwise cnt[i] increments. When cnt[i] == DEBOUNCE_CYCLES-1, o_key[i] <= s[i] and cnt[i] <= 0.
//   - A glitch shorter than DEBOUNCE_CYCLES restarts the count and changes nothing.
//  Press detection
//   - A press is a 1->0 transition of o_key[i].
//   - It sets o_pending[i] on the next edge only if i_ie[i]=1. Releases are ignored.
//  Pending clear sources
//   - i_clr & i_clr_mask[i].
//   - i_ack while in REQ clears the latched o_cause_ip bit.
//   - If a press-set and a clear hit the same bit in the same cycle, the set wins.
//  Selection
//   - sel = lowest index i with o_pending[i] & i_ie[i].
//  FSM (registered outputs)
//   - IDLE: if i_gie & |(o_pending & i_ie) -> REQ; o_irq <= 1; o_cause_ip <= onehot(sel).
//   - REQ:
//     - i_ack -> SERVICE; o_irq <= 0; o_cause_ip is held.
//     - else if !i_gie or the latched line is no longer pending&enabled -> IDLE; o_irq <= 0; o_cause_ip <= 0.
//     - i_ack takes priority over the withdraw condition.
//   - SERVICE: o_irq stays 0. i_eret -> IDLE; o_cause_ip <= 0. Presses keep setting pending during SERVICE.
//   - i_ack outside REQ and i_eret outside SERVICE are ignored.
//  Latency
//   - Raw press held stable to o_pending: 2 + DEBOUNCE_CYCLES + 1 cycles.
//   - o_pending to o_irq: 1 cycle.
//  Reset asserted mid-operation
//   - Returns everything to its reset values immediately.
//   - Pending presses are lost.
// TESTING (sim with DEBOUNCE_CYCLES=4)
//  1. ie=01, gie=1, key0 low held 10 cycles
//     -> o_pending=01 on cycle 7; o_irq=1, o_cause_ip=01 on cycle 8.
//     ack -> o_irq=0, pending=00; eret -> cause=00.
//  2. key0 low for 3 cycles, then high -> o_key stays 11, no pending, no irq.
//  3. key0 and key1 pressed together, ie=11 -> cause=01 first.
//     After ack+eret -> o_irq reasserts with cause=10.
//  4. In SERVICE, key1 pressed -> pending=10, o_irq stays 0 until eret; then o_irq=1 one cycle after eret.
//  5. In REQ, gie dropped -> o_irq=0 next cycle and FSM goes to IDLE with pending kept.
//     gie restored -> o_irq=1 again.
//  6. Reset pulsed during REQ and during debounce counting
//     -> all outputs at reset values; a half-counted press produces no pending.

Source files
------------

// File: rtl/key_irq_ctrl.sv
// Key interrupt source: synchronises and debounces active-low keys, latches presses as
// pending flags and raises one prioritised, non-nesting interrupt request to the core.
module key_irq_ctrl #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] i_key,
  input  logic [N_KEYS-1:0] i_ie,
  input  logic              i_gie,
  input  logic              i_ack,
  input  logic              i_eret,
  input  logic              i_clr,
  input  logic [N_KEYS-1:0] i_clr_mask,
  output logic              o_irq,
  output logic [N_KEYS-1:0] o_cause_ip,
  output logic [N_KEYS-1:0] o_pending,
  output logic [N_KEYS-1:0] o_key
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } StateType;

  StateType          state;
  logic [N_KEYS-1:0] syncMeta;
  logic [N_KEYS-1:0] syncKey;
  logic [N_KEYS-1:0] keyLevel;
  logic [N_KEYS-1:0] keyPrev;
  logic [N_KEYS-1:0] pressSet;
  logic [N_KEYS-1:0] clrBits;
  logic [N_KEYS-1:0] pendEn;
  logic [N_KEYS-1:0] selOneHot;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      syncMeta <= '1;
      syncKey  <= '1;
    end else begin
      syncMeta <= i_key;
      syncKey  <= syncMeta;
    end
  end

  // A level is accepted only after it has differed from the current one for DEBOUNCE_CYCLES samples.
  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : gDebounce
      logic [CNT_W-1:0] cnt;
      logic             level;

      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          cnt   <= '0;
          level <= 1'b1;
        end else if (syncKey[gi] == level) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= syncKey[gi];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign keyLevel[gi] = level;
    end
  endgenerate

  assign o_key = keyLevel;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      keyPrev <= '1;
    end else begin
      keyPrev <= keyLevel;
    end
  end

  // Press = falling edge of the debounced level; set has priority over any clear.
  assign pressSet = keyPrev & ~keyLevel & i_ie;
  assign clrBits  = ({N_KEYS{i_clr}} & i_clr_mask)
                  | (((state == REQ) && i_ack) ? o_cause_ip : '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      o_pending <= '0;
    end else begin
      o_pending <= (o_pending & ~clrBits) | pressSet;
    end
  end

  // Isolate the lowest set bit: line 0 has the highest priority.
  assign pendEn    = o_pending & i_ie;
  assign selOneHot = pendEn & (~pendEn + N_KEYS'(1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      o_irq      <= 1'b0;
      o_cause_ip <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_gie && (pendEn != '0)) begin
            state      <= REQ;
            o_irq      <= 1'b1;
            o_cause_ip <= selOneHot;
          end
        end
        REQ: begin
          if (i_ack) begin
            state <= SERVICE;
            o_irq <= 1'b0;
          end else if (!i_gie || ((o_cause_ip & pendEn) == '0)) begin
            state      <= IDLE;
            o_irq      <= 1'b0;
            o_cause_ip <= '0;
          end
        end
        SERVICE: begin
          o_irq <= 1'b0;
          if (i_eret) begin
            state      <= IDLE;
            o_cause_ip <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          o_irq      <= 1'b0;
          o_cause_ip <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Bench for key_irq_ctrl: directed vector table, reset corner cases, then random
// stimulus compared every cycle against a behavioural model of the key interrupt source.
module tb_key_irq_ctrl;

  localparam int NK  = 2;
  localparam int DEB = 4;
  localparam int CW  = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [NK-1:0] key = 2'b11;
  logic [NK-1:0] ie = 2'b00;
  logic          gie = 1'b0;
  logic          ack = 1'b0;
  logic          eret = 1'b0;
  logic          clr = 1'b0;
  logic [NK-1:0] clrMask = 2'b00;
  logic          irq;
  logic [NK-1:0] cause;
  logic [NK-1:0] pend;
  logic [NK-1:0] okey;

  int nTests = 0;
  int nFail  = 0;

  always #5 Clk = ~Clk;

  key_irq_ctrl #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_key     (key),
    .i_ie      (ie),
    .i_gie     (gie),
    .i_ack     (ack),
    .i_eret    (eret),
    .i_clr     (clr),
    .i_clr_mask(clrMask),
    .o_irq     (irq),
    .o_cause_ip(cause),
    .o_pending (pend),
    .o_key     (okey)
  );

  typedef struct packed {
    logic [1:0] key;
    logic [1:0] ie;
    logic       gie;
    logic       ack;
    logic       eret;
    logic       clr;
    logic [1:0] mask;
    logic [7:0] hold;
    logic [1:0] eKey;
    logic [1:0] ePend;
    logic       eIrq;
    logic [1:0] eCause;
  } VecType;

  VecType vecs[$];

  task automatic addV(input logic [1:0] k, input logic [1:0] e, input logic g, input logic a,
                      input logic r, input logic c, input logic [1:0] m, input int h,
                      input logic [1:0] xk, input logic [1:0] xp, input logic xi,
                      input logic [1:0] xc);
    VecType v;
    v.key = k; v.ie = e; v.gie = g; v.ack = a; v.eret = r; v.clr = c; v.mask = m;
    v.hold = 8'(h); v.eKey = xk; v.ePend = xp; v.eIrq = xi; v.eCause = xc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [1:0] xk, input logic [1:0] xp,
                       input logic xi, input logic [1:0] xc);
    nTests++;
    if ({okey, pend, irq, cause} !== {xk, xp, xi, xc}) begin
      nFail++;
      $display("FAIL %s: got key=%b pend=%b irq=%b cause=%b, expected key=%b pend=%b irq=%b cause=%b",
               name, okey, pend, irq, cause, xk, xp, xi, xc);
    end
  endtask

  // Behavioural reference: debounce = "last DEB synchronised samples all opposite to the accepted level".
  logic [NK-1:0]  mS1, mS2, mKey, mPrev, mPend, mCause;
  logic           mIrq;
  logic [DEB-1:0] mHist [NK];
  int             mState;  // 0 idle, 1 requesting, 2 in service

  task automatic modelReset();
    mS1 = '1; mS2 = '1; mKey = '1; mPrev = '1;
    mPend = '0; mCause = '0; mIrq = 1'b0; mState = 0;
    for (int i = 0; i < NK; i++) mHist[i] = '1;
  endtask

  task automatic modelStep();
    logic [NK-1:0]  keyN, setB, clrB, pendEn, sel;
    logic [DEB-1:0] h;
    keyN = mKey;
    for (int i = 0; i < NK; i++) begin
      h = {mHist[i][DEB-2:0], mS2[i]};
      mHist[i] = h;
      if (h == {DEB{~mKey[i]}}) keyN[i] = ~mKey[i];
    end
    setB   = mPrev & ~mKey & ie;
    clrB   = (clr ? clrMask : 2'b00) | (((mState == 1) && ack) ? mCause : 2'b00);
    pendEn = mPend & ie;
    sel    = '0;
    for (int i = NK - 1; i >= 0; i--) if (pendEn[i]) sel = 2'b01 << i;
    case (mState)
      0: if (gie && pendEn != 0) begin mState = 1; mIrq = 1'b1; mCause = sel; end
      1: begin
        if (ack) begin
          mState = 2; mIrq = 1'b0;
        end else if (!gie || (mCause & pendEn) == 0) begin
          mState = 0; mIrq = 1'b0; mCause = '0;
        end
      end
      default: if (eret) begin mState = 0; mCause = '0; end
    endcase
    mPend = (mPend & ~clrB) | setB;
    mPrev = mKey;
    mKey  = keyN;
    mS2   = mS1;
    mS1   = key;
  endtask

  task automatic setIn(input logic [1:0] k, input logic [1:0] e, input logic g, input logic a,
                       input logic r, input logic c, input logic [1:0] m);
    key = k; ie = e; gie = g; ack = a; eret = r; clr = c; clrMask = m;
  endtask

  int keyLeft [NK];

  initial begin
    // key, ie, gie, ack, eret, clr, mask, hold | key, pend, irq, cause
    // Single press: pending after 7 edges, irq after 8, ack, eret.
    addV(2'b10, 2'b01, 1, 0, 0, 0, 2'b00, 6, 2'b10, 2'b00, 0, 2'b00);
    addV(2'b10, 2'b01, 1, 0, 0, 0, 2'b00, 1, 2'b10, 2'b01, 0, 2'b00);
    addV(2'b10, 2'b01, 1, 0, 0, 0, 2'b00, 1, 2'b10, 2'b01, 1, 2'b01);
    addV(2'b10, 2'b01, 1, 1, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 2'b01);
    addV(2'b10, 2'b01, 1, 0, 0, 0, 2'b00, 2, 2'b10, 2'b00, 0, 2'b01);
    addV(2'b10, 2'b01, 1, 0, 1, 0, 2'b00, 1, 2'b10, 2'b00, 0, 2'b00);
    addV(2'b10, 2'b01, 1, 0, 0, 0, 2'b00, 2, 2'b10, 2'b00, 0, 2'b00);
    addV(2'b11, 2'b01, 1, 0, 0, 0, 2'b00, 6, 2'b11, 2'b00, 0, 2'b00);
    // Glitch of 3 cycles is rejected.
    addV(2'b10, 2'b01, 1, 0, 0, 0, 2'b00, 3, 2'b11, 2'b00, 0, 2'b00);
    addV(2'b11, 2'b01, 1, 0, 0, 0, 2'b00, 8, 2'b11, 2'b00, 0, 2'b00);
    // Simultaneous presses: line 0 first, line 1 after eret.
    addV(2'b00, 2'b11, 1, 0, 0, 0, 2'b00, 7, 2'b00, 2'b11, 0, 2'b00);
    addV(2'b00, 2'b11, 1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b11, 1, 2'b01);
    addV(2'b00, 2'b11, 1, 1, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 2'b01);
    addV(2'b00, 2'b11, 1, 0, 1, 0, 2'b00, 1, 2'b00, 2'b10, 0, 2'b00);
    addV(2'b00, 2'b11, 1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 1, 2'b10);
    addV(2'b00, 2'b11, 1, 1, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b10);
    addV(2'b00, 2'b11, 1, 0, 1, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00);
    addV(2'b11, 2'b11, 1, 0, 0, 0, 2'b00, 6, 2'b11, 2'b00, 0, 2'b00);
    // Press during SERVICE waits for eret.
    addV(2'b10, 2'b11, 1, 0, 0, 0, 2'b00, 8, 2'b10, 2'b01, 1, 2'b01);
    addV(2'b10, 2'b11, 1, 1, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 2'b01);
    addV(2'b00, 2'b11, 1, 0, 0, 0, 2'b00, 7, 2'b00, 2'b10, 0, 2'b01);
    addV(2'b00, 2'b11, 1, 0, 0, 0, 2'b00, 3, 2'b00, 2'b10, 0, 2'b01);
    addV(2'b00, 2'b11, 1, 0, 1, 0, 2'b00, 1, 2'b00, 2'b10, 0, 2'b00);
    addV(2'b00, 2'b11, 1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 1, 2'b10);
    // Global enable dropped while requesting, then restored.
    addV(2'b00, 2'b11, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 2'b00);
    addV(2'b00, 2'b11, 0, 0, 0, 0, 2'b00, 3, 2'b00, 2'b10, 0, 2'b00);
    addV(2'b00, 2'b11, 1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 1, 2'b10);
    addV(2'b00, 2'b11, 1, 1, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b10);
    addV(2'b00, 2'b11, 1, 0, 1, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00);
    addV(2'b11, 2'b11, 1, 0, 0, 0, 2'b00, 6, 2'b11, 2'b00, 0, 2'b00);
    // Software clear, and set winning over a same-cycle clear.
    addV(2'b10, 2'b01, 0, 0, 0, 0, 2'b00, 6, 2'b10, 2'b00, 0, 2'b00);
    addV(2'b10, 2'b01, 0, 0, 0, 1, 2'b01, 1, 2'b10, 2'b01, 0, 2'b00);
    addV(2'b10, 2'b01, 0, 0, 0, 1, 2'b01, 1, 2'b10, 2'b00, 0, 2'b00);
    addV(2'b11, 2'b01, 0, 0, 0, 0, 2'b00, 6, 2'b11, 2'b00, 0, 2'b00);
    // Disabled line never becomes pending.
    addV(2'b01, 2'b00, 1, 0, 0, 0, 2'b00, 8, 2'b01, 2'b00, 0, 2'b00);
    addV(2'b11, 2'b00, 1, 0, 0, 0, 2'b00, 6, 2'b11, 2'b00, 0, 2'b00);
    // Clearing the requested line withdraws the request.
    addV(2'b10, 2'b01, 1, 0, 0, 0, 2'b00, 8, 2'b10, 2'b01, 1, 2'b01);
    addV(2'b10, 2'b01, 1, 0, 0, 1, 2'b01, 1, 2'b10, 2'b00, 1, 2'b01);
    addV(2'b10, 2'b01, 1, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 2'b00);
    addV(2'b11, 2'b01, 1, 0, 0, 0, 2'b00, 6, 2'b11, 2'b00, 0, 2'b00);

    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1 check("reset_state", 2'b11, 2'b00, 1'b0, 2'b00);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      setIn(vecs[i].key, vecs[i].ie, vecs[i].gie, vecs[i].ack, vecs[i].eret, vecs[i].clr, vecs[i].mask);
      repeat (int'(vecs[i].hold)) @(posedge Clk);
      #1 check($sformatf("vec%0d", i), vecs[i].eKey, vecs[i].ePend, vecs[i].eIrq, vecs[i].eCause);
    end

    // Reset while requesting.
    setIn(2'b10, 2'b01, 1, 0, 0, 0, 2'b00);
    repeat (8) @(posedge Clk);
    #1 check("pre_reset_req", 2'b10, 2'b01, 1'b1, 2'b01);
    Reset = 1'b0;
    #1 check("reset_in_req", 2'b11, 2'b00, 1'b0, 2'b00);
    key = 2'b11;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    repeat (10) @(posedge Clk);
    #1 check("after_reset_req", 2'b11, 2'b00, 1'b0, 2'b00);

    // Reset while the debounce counter is half way.
    key = 2'b10;
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b0;
    key = 2'b11;
    #1 check("reset_in_count", 2'b11, 2'b00, 1'b0, 2'b00);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    repeat (10) @(posedge Clk);
    #1 check("half_press_lost", 2'b11, 2'b00, 1'b0, 2'b00);

    // Random traffic against the reference model.
    Reset = 1'b0;
    setIn(2'b11, 2'b11, 1, 0, 0, 0, 2'b00);
    modelReset();
    for (int i = 0; i < NK; i++) keyLeft[i] = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (keyLeft[i] == 0) begin
          key[i]     = 1'($urandom_range(0, 1));
          keyLeft[i] = $urandom_range(1, 9);
        end
        keyLeft[i]--;
      end
      if ($urandom_range(0, 31) == 0) ie = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) gie = ~gie;
      ack     = ($urandom_range(0, 2) == 0);
      eret    = ($urandom_range(0, 3) == 0);
      clr     = ($urandom_range(0, 15) == 0);
      clrMask = 2'($urandom_range(0, 3));
      @(posedge Clk);
      modelStep();
      #1 check($sformatf("rand%0d", c), mKey, mPend, mIrq, mCause);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
